// File: rtl/lsnn_neuron_scheduler.sv
// lsnn_neuron_scheduler
//   Time-multiplexes one adaptive leaky-integrate (LSNN) neuron datapath over
//   N_NEURONS virtual neurons. Per-neuron membrane (v), adaptation (a) and
//   threshold (thr) are held in internal register arrays.
//
//   Operation: a step_valid handshake in IDLE starts a sweep. For each neuron,
//   the current is fetched through cur_idx/cur_in, then the neuron is updated
//   and written back. The spike vector is published together with a
//   one-cycle step_done pulse when the sweep completes.
//
//   Optional feature: define LSNN_REFRACTORY_EN to add a per-neuron
//   refractory flag. A spiking neuron is reset to v=0. In the following sweep
//   it ignores its input, cannot spike, and decays its adaptation.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ena          global enable; low freezes FSM, counters, arrays, cur_idx
//   step_valid   request one timestep (accepted only in IDLE)
//   step_ready   high only in IDLE
//   cur_idx      index of the neuron whose current is requested
//   cur_in       current for cur_idx, registered at the end of FETCH
//   spikes       spike vector of the last completed step
//   step_done    one-cycle pulse when spikes has been updated
//   thr_sel      debug select
//   thr_out      threshold of neuron thr_sel (combinational array read)

module lsnn_neuron_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ALPHA     = 8,
    parameter int unsigned B0        = 8,
    localparam int unsigned IDXW     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 step_valid,
    output logic                 step_ready,
    output logic [IDXW-1:0]      cur_idx,
    input  logic [WIDTH-1:0]     cur_in,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 step_done,
    input  logic [IDXW-1:0]      thr_sel,
    output logic [WIDTH-1:0]     thr_out
);

    // Arrays are sized to the full index range, so any thr_sel is a legal read.
    localparam int unsigned DEPTH = 1 << IDXW;
    localparam logic [IDXW-1:0]  LAST    = IDXW'(N_NEURONS - 1);
    localparam logic [WIDTH-1:0] ALPHA_W = WIDTH'(ALPHA);
    localparam logic [WIDTH-1:0] B0_W    = WIDTH'(B0);

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

    state_t                state;
    logic [IDXW-1:0]       n;
    logic [WIDTH-1:0]      cur_reg;
    logic [N_NEURONS-1:0]  spike_shadow;

    logic [WIDTH-1:0] v_mem   [DEPTH];
    logic [WIDTH-1:0] a_mem   [DEPTH];
    logic [WIDTH-1:0] thr_mem [DEPTH];
`ifdef LSNN_REFRACTORY_EN
    logic [DEPTH-1:0] refr;
`endif

    // Datapath for neuron n.
    logic [WIDTH-1:0]     v_old, a_old, thr_old;
    logic [WIDTH:0]       v_sum, a_sum, thr_sum;
    logic [WIDTH-1:0]     v_new, v_wr, a_new, thr_new;
    logic                 spike;
    logic [N_NEURONS-1:0] shadow_next;

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] s);
        return s[WIDTH] ? '1 : s[WIDTH-1:0];
    endfunction

    always_comb begin
        v_old   = v_mem[n];
        a_old   = a_mem[n];
        thr_old = thr_mem[n];
        v_sum   = {1'b0, cur_reg} + {1'b0, (v_old >> 1)};
        v_new   = sat(v_sum);
        spike   = (v_new >= thr_old);
        v_wr    = v_new;
`ifdef LSNN_REFRACTORY_EN
        if (refr[n]) begin
            v_new = '0;
            spike = 1'b0;
        end
        // A spiking neuron restarts from rest.
        v_wr = spike ? '0 : v_new;
`endif
        a_sum       = {1'b0, a_old} + {1'b0, (a_old >> 2)};
        a_new       = spike ? sat(a_sum) : (a_old >> 1) + (a_old >> 2);
        thr_sum     = {1'b0, B0_W} + {1'b0, a_new};
        thr_new     = sat(thr_sum);
        shadow_next = spike_shadow;
        shadow_next[n] = spike;
    end

    assign thr_out = thr_mem[thr_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            n            <= '0;
            cur_idx      <= '0;
            cur_reg      <= '0;
            spike_shadow <= '0;
            spikes       <= '0;
            step_done    <= 1'b0;
            step_ready   <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                v_mem[i]   <= '0;
                a_mem[i]   <= ALPHA_W;
                thr_mem[i] <= B0_W;
            end
`ifdef LSNN_REFRACTORY_EN
            refr <= '0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        n          <= '0;
                        cur_idx    <= '0;
                        step_ready <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    cur_reg <= cur_in;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    v_mem[n]     <= v_wr;
                    a_mem[n]     <= a_new;
                    thr_mem[n]   <= thr_new;
                    spike_shadow <= shadow_next;
`ifdef LSNN_REFRACTORY_EN
                    // Set on spike; a refractory neuron cannot spike, so it clears.
                    refr[n] <= spike;
`endif
                    if (n == LAST) begin
                        // Publish on entry to DONE so spikes is valid
                        // in the same cycle as step_done.
                        spikes    <= shadow_next;
                        step_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        n       <= n + 1'b1;
                        cur_idx <= n + 1'b1;
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    step_done  <= 1'b0;
                    step_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// tb_lsnn_neuron_scheduler
//   Scoreboard bench for lsnn_neuron_scheduler (default parameters: 4 neurons,
//   8-bit, ALPHA=8, B0=8). Stimulus pushes the expected spike vector,
//   thresholds and completion cycle for each step into a queue. The monitor
//   pops an entry on every step_done and checks the reset state after every
//   reset. The expected values for the refractory feature are selected with
//   LSNN_REFRACTORY_EN.
`timescale 1ns/1ps

module tb_lsnn_neuron_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       step_valid = 1'b0;
    logic       step_ready;
    logic [1:0] cur_idx;
    logic [7:0] cur_in;
    logic [3:0] spikes;
    logic       step_done;
    logic [1:0] thr_sel = 2'd0;
    logic [7:0] thr_out;

    logic [7:0] cur_tab [4];
    assign cur_in = cur_tab[cur_idx];

    lsnn_neuron_scheduler #(.N_NEURONS(4), .WIDTH(8), .ALPHA(8), .B0(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step_valid(step_valid),
        .step_ready(step_ready), .cur_idx(cur_idx), .cur_in(cur_in),
        .spikes(spikes), .step_done(step_done), .thr_sel(thr_sel),
        .thr_out(thr_out)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    logic        ena_edge = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ena_edge <= ena;
    end

    typedef struct {
        logic [3:0]  sp;
        logic [31:0] thr;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: reset-state checks and scoreboard pops on step_done.
    initial begin : monitor
        logic        done_prev;
        logic        rst_seen;
        logic [31:0] hist;
        exp_t        e;
        done_prev = 1'b0;
        rst_seen  = 1'b0;
        hist      = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                rst_seen  = 1'b1;
                done_prev = 1'b0;
            end else begin
                if (rst_seen) begin
                    rst_seen = 1'b0;
                    chk("rst_ready", 32'(step_ready), 32'd1);
                    chk("rst_done", 32'(step_done), 32'd0);
                    chk("rst_spikes", 32'(spikes), 32'd0);
                    chk("rst_cur_idx", 32'(cur_idx), 32'd0);
                    for (int i = 0; i < 4; i++) begin
                        thr_sel = 2'(i);
                        #1;
                        chk($sformatf("rst_thr%0d", i), 32'(thr_out), 32'd8);
                    end
                    thr_sel = 2'd0;
                end
                if (step_done && !done_prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_step_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("spikes", 32'(spikes), 32'(e.sp));
                        chk("done_cycle", cyc, e.cyc);
                        chk("cur_idx_seq", hist, 32'h00112233);
                        for (int i = 0; i < 4; i++) begin
                            thr_sel = 2'(i);
                            #1;
                            chk($sformatf("thr%0d", i), 32'(thr_out), 32'(e.thr[8*i +: 8]));
                        end
                        thr_sel = 2'd0;
                    end
                end
                done_prev = step_done;
                // Cycles after a frozen edge repeat the previous cycle.
                if (ena_edge)
                    hist = {hist[27:0], 2'b00, cur_idx};
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // curs / thr packed per neuron: neuron i in bits [8i+7:8i].
    task automatic do_step(input logic [31:0] curs, input logic [3:0] sp,
                           input logic [31:0] thr, input int unsigned frz);
        exp_t e;
        int   k;
        for (int i = 0; i < 4; i++) cur_tab[i] = curs[8*i +: 8];
        @(negedge clk);
        chk("ready_before_step", 32'(step_ready), 32'd1);
        e.sp  = sp;
        e.thr = thr;
        e.cyc = cyc + 9 + frz;
        q.push_back(e);
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        if (frz > 0) begin
            repeat (2) @(negedge clk);
            step_valid = 1'b1;  // mid-sweep request, must be ignored
            @(negedge clk);
            step_valid = 1'b0;
            ena = 1'b0;
            repeat (frz) @(negedge clk);
            ena = 1'b1;
        end
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("step_done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic abort_step(input logic [31:0] curs);
        for (int i = 0; i < 4; i++) cur_tab[i] = curs[8*i +: 8];
        @(negedge clk);
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        for (int i = 0; i < 4; i++) cur_tab[i] = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // All currents zero, with an ena freeze and an ignored step_valid.
        do_step(32'h00000000, 4'b0000, 32'h0E0E0E0E, 3);

        // Neuron 0 spikes, then decays.
        do_reset();
        do_step(32'h00000014, 4'b0001, 32'h0E0E0E12, 0);
        do_step(32'h00000000, 4'b0000, 32'h0C0C0C0F, 0);

        // Neuron 1 driven at full scale for three steps.
        do_reset();
        do_step(32'h0000FF00, 4'b0010, 32'h0E0E120E, 0);
`ifdef LSNN_REFRACTORY_EN
        do_step(32'h0000FF00, 4'b0000, 32'h0C0C0F0C, 0);
        do_step(32'h0000FF00, 4'b0010, 32'h0B0B100B, 0);
`else
        do_step(32'h0000FF00, 4'b0010, 32'h0C0C140C, 0);
        do_step(32'h0000FF00, 4'b0010, 32'h0B0B170B, 0);
`endif

        // Reset mid-sweep discards the sweep; a fresh step starts clean.
        do_reset();
        abort_step(32'h00000014);
        do_step(32'h00000014, 4'b0001, 32'h0E0E0E12, 0);

        // Neuron 0 driven at 20 twice.
        do_reset();
        do_step(32'h00000014, 4'b0001, 32'h0E0E0E12, 0);
`ifdef LSNN_REFRACTORY_EN
        do_step(32'h00000014, 4'b0000, 32'h0C0C0C0F, 0);
`else
        do_step(32'h00000014, 4'b0001, 32'h0C0C0C14, 0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
